// File: rtl/uart_ascii_tx.sv
// Purpose : 8N1 UART transmitter for ASCII characters (echo / status text).
// Latency : start bit is driven on the accept edge; frame is 10*CLKS_PER_BIT
//           cycles, or 11*CLKS_PER_BIT with the parity bit.
// Backpr. : no queue. data_valid is only accepted while idle (tx_busy=0), and
//           requests made during a frame are dropped.
// Optional: define UART_TX_PARITY_EN to insert an even-parity bit between the
//           data bits and the stop bit.
// Ports   : clk, rst (async, active-high), ascii_data[7:0], data_valid,
//           tx (idle high), tx_busy, tx_done (one-cycle pulse at frame end).
module uart_ascii_tx #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ascii_data,
  input  logic       data_valid,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_reg;
`ifdef UART_TX_PARITY_EN
  logic              parity_bit;
`endif

  logic bit_end;
  assign bit_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (data_valid) begin
            // Start bit goes out on the accept edge itself.
            shift_reg <= ascii_data;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^ascii_data;
`endif
            baud_cnt  <= '0;
            bit_idx   <= '0;
            tx        <= 1'b0;
            tx_busy   <= 1'b1;
            state     <= START;
          end
        end

        START: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            tx        <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[7:1]};
            state     <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              tx    <= parity_bit;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              // LSB-first: the next bit is always at the bottom of the shifter.
              bit_idx   <= bit_idx + 3'd1;
              tx        <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
`endif

        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b1;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
